// File: rtl/mt_regfile.sv
// Multi-thread register file: 2 registered read ports (1-cycle latency), 1 write port, FSM-driven context clear.
// No backpressure; init_req is ignored while init_busy. Define MT_REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
module mt_regfile #(
  parameter int                 NUM_TRD      = 8,
  parameter int                 NUM_REG      = 32,
  parameter int                 DATA_W       = 32,
  parameter logic [DATA_W-1:0]  STACK_TOP    = 32'h0001_0FFF,
  parameter logic [DATA_W-1:0]  STACK_STRIDE = 32'h0000_0100,
  localparam int                TW           = $clog2(NUM_TRD),
  localparam int                RW           = $clog2(NUM_REG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TW-1:0]     rd_trd,
  input  logic [RW-1:0]     rd_a,
  input  logic [RW-1:0]     rd_b,
  input  logic              wr_en,
  input  logic [TW-1:0]     wr_trd,
  input  logic [RW-1:0]     wr_reg,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init_req,
  input  logic [TW-1:0]     init_trd,
  input  logic [DATA_W-1:0] init_data,
  output logic              init_busy,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [RW-1:0]       clr_ptr_q, clr_ptr_d;
  logic [TW-1:0]       clr_trd_q, clr_trd_d;
  logic [DATA_W-1:0]   data_a_q, data_a_d;
  logic [DATA_W-1:0]   data_b_q, data_b_d;
  logic [DATA_W-1:0]   regs_q [NUM_TRD][NUM_REG];
  logic [DATA_W-1:0]   regs_d [NUM_TRD][NUM_REG];

  logic init_acc;
  logic wr_ok;
  logic hide_a, hide_b;

  // Fixed context layout: r0=0, r1=thread id, r2/r3=initial stack pointer, r4=argument.
  function automatic logic [DATA_W-1:0] ctx_val(input int t, input int r, input logic [DATA_W-1:0] arg);
    case (r)
      0:       return '0;
      1:       return DATA_W'(t);
      2, 3:    return STACK_TOP - DATA_W'(t) * STACK_STRIDE;
      4:       return arg;
      default: return '0;
    endcase
  endfunction

  assign init_busy = (state_q == CLEAR);
  assign init_acc  = (state_q == IDLE) && init_req;
  assign wr_ok     = wr_en && (wr_reg > RW'(1))
                     && !(init_acc && (wr_trd == init_trd))
                     && !(init_busy && (wr_trd == clr_trd_q));
  assign hide_a    = init_busy && (rd_trd == clr_trd_q) && (rd_a >= clr_ptr_q);
  assign hide_b    = init_busy && (rd_trd == clr_trd_q) && (rd_b >= clr_ptr_q);

  always_comb begin
    regs_d    = regs_q;
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    clr_trd_d = clr_trd_q;

    if (wr_ok) begin
      regs_d[wr_trd][wr_reg] = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (init_req) begin
          regs_d[init_trd][0] = ctx_val(int'(init_trd), 0, init_data);
          regs_d[init_trd][1] = ctx_val(int'(init_trd), 1, init_data);
          regs_d[init_trd][2] = ctx_val(int'(init_trd), 2, init_data);
          regs_d[init_trd][3] = ctx_val(int'(init_trd), 3, init_data);
          regs_d[init_trd][4] = ctx_val(int'(init_trd), 4, init_data);
          clr_ptr_d = RW'(5);
          clr_trd_d = init_trd;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        regs_d[clr_trd_q][clr_ptr_q] = '0;
        clr_ptr_d = clr_ptr_q + RW'(1);
        if (clr_ptr_q == RW'(NUM_REG - 1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read path uses pre-edge storage; entries not yet cleared by the FSM read as zero.
  always_comb begin
    data_a_d = regs_q[rd_trd][rd_a];
    data_b_d = regs_q[rd_trd][rd_b];
`ifdef MT_REGFILE_BYPASS_EN
    if (wr_ok && (wr_trd == rd_trd) && (wr_reg == rd_a)) data_a_d = wr_data;
    if (wr_ok && (wr_trd == rd_trd) && (wr_reg == rd_b)) data_b_d = wr_data;
`endif
    if (hide_a) data_a_d = '0;
    if (hide_b) data_b_d = '0;
    if (rd_a == '0)        data_a_d = '0;
    else if (rd_a == RW'(1)) data_a_d = DATA_W'(rd_trd);
    if (rd_b == '0)        data_b_d = '0;
    else if (rd_b == RW'(1)) data_b_d = DATA_W'(rd_trd);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < NUM_TRD; t++) begin
        for (int r = 0; r < NUM_REG; r++) begin
          regs_q[TW'(t)][RW'(r)] <= ctx_val(t, r, '0);
        end
      end
      state_q   <= IDLE;
      clr_ptr_q <= '0;
      clr_trd_q <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
    end else begin
      regs_q    <= regs_d;
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      clr_trd_q <= clr_trd_d;
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: tb/tb_mt_regfile.sv
// Directed testbench for mt_regfile at default parameters.
module tb_mt_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_trd;
  logic [4:0]  rd_a, rd_b;
  logic        wr_en;
  logic [2:0]  wr_trd;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic        init_req;
  logic [2:0]  init_trd;
  logic [31:0] init_data;
  logic        init_busy;
  logic [31:0] data_a, data_b;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  mt_regfile dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_trd    (rd_trd),
    .rd_a      (rd_a),
    .rd_b      (rd_b),
    .wr_en     (wr_en),
    .wr_trd    (wr_trd),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .init_req  (init_req),
    .init_trd  (init_trd),
    .init_data (init_data),
    .init_busy (init_busy),
    .data_a    (data_a),
    .data_b    (data_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int t, input int a, input int b);
    rd_trd = 3'(t);
    rd_a   = 5'(a);
    rd_b   = 5'(b);
    tick();
  endtask

  task automatic wr(input int t, input int r, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_trd  = 3'(t);
    wr_reg  = 5'(r);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rd_trd = '0; rd_a = '0; rd_b = '0;
    wr_en = 1'b0; wr_trd = '0; wr_reg = '0; wr_data = '0;
    init_req = 1'b0; init_trd = '0; init_data = '0;
    #1;
    chk("rst_busy", 32'(init_busy), 32'h0);
    chk("rst_data_a", data_a, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset layout, threads 0 and 3
    rd(0, 0, 1); chk("t0_r0", data_a, 32'h0);         chk("t0_r1", data_b, 32'h0);
    rd(0, 2, 3); chk("t0_r2", data_a, 32'h0001_0FFF); chk("t0_r3", data_b, 32'h0001_0FFF);
    rd(0, 4, 0); chk("t0_r4", data_a, 32'h0);
    rd(3, 1, 2); chk("t3_r1", data_a, 32'h3);         chk("t3_r2", data_b, 32'h0001_0CFF);
    rd(3, 3, 4); chk("t3_r3", data_a, 32'h0001_0CFF); chk("t3_r4", data_b, 32'h0);

    // Same-cycle write and read of t2 r7
    rd_trd = 3'd2; rd_a = 5'd7; rd_b = 5'd0;
    wr(2, 7, 32'hDEAD_BEEF);
`ifdef MT_REGFILE_BYPASS_EN
    chk("bypass_same", data_a, 32'hDEAD_BEEF);
`else
    chk("nobypass_same", data_a, 32'h0);
`endif
    tick();
    chk("wr_next", data_a, 32'hDEAD_BEEF);

    // r0/r1 are read-only
    wr(5, 0, 32'hFFFF_FFFF);
    wr(5, 1, 32'hFFFF_FFFF);
    rd(5, 0, 1); chk("t5_r0_ro", data_a, 32'h0); chk("t5_r1_ro", data_b, 32'h5);

    // Fill t1 and mark t0
    for (int r = 5; r < 32; r++) wr(1, r, 32'hA5A5_A5A5);
    wr(0, 20, 32'h0BAD_F00D);
    rd(1, 31, 5); chk("t1_fill31", data_a, 32'hA5A5_A5A5); chk("t1_fill5", data_b, 32'hA5A5_A5A5);

    // Init t1; accept-cycle read sees old contents
    rd_trd = 3'd1; rd_a = 5'd4; rd_b = 5'd31;
    init_req = 1'b1; init_trd = 3'd1; init_data = 32'h0000_1234;
    tick();
    init_req = 1'b0;
    chk("acc_pre_r4", data_a, 32'h0);
    chk("acc_pre_r31", data_b, 32'hA5A5_A5A5);
    chk("busy_rise", 32'(init_busy), 32'h1);
    busy_cnt = init_busy ? 1 : 0;

    // Mid-clear: read ahead of clr_ptr, dropped write to t1, second request ignored
    rd_a = 5'd20; rd_b = 5'd4;
    wr_en = 1'b1; wr_trd = 3'd1; wr_reg = 5'd10; wr_data = 32'h77;
    init_req = 1'b1; init_trd = 3'd2; init_data = 32'h99;
    tick();
    if (init_busy) busy_cnt++;
    chk("mid_ahead", data_a, 32'h0);
    chk("mid_r4", data_b, 32'h0000_1234);

    wr_trd = 3'd6; wr_reg = 5'd10; wr_data = 32'h55;
    init_req = 1'b0; rd_a = 5'd31; rd_b = 5'd3;
    tick();
    wr_en = 1'b0;
    if (init_busy) busy_cnt++;
    chk("mid_r31", data_a, 32'h0);
    chk("mid_r3", data_b, 32'h0001_0EFF);

    for (int i = 0; i < 40 && init_busy; i++) begin
      tick();
      if (init_busy) busy_cnt++;
    end
    chk("busy_len", 32'(busy_cnt), 32'd27);
    chk("busy_fall", 32'(init_busy), 32'h0);

    rd(1, 4, 10); chk("t1_r4", data_a, 32'h0000_1234); chk("t1_r10_drop", data_b, 32'h0);
    for (int r = 5; r < 32; r++) begin
      rd(1, r, 1);
      chk($sformatf("t1_clr_r%0d", r), data_a, 32'h0);
    end
    chk("t1_r1", data_b, 32'h1);
    rd(6, 10, 0); chk("t6_r10", data_a, 32'h55);
    rd(0, 20, 2); chk("t0_keep", data_a, 32'h0BAD_F00D); chk("t0_esp", data_b, 32'h0001_0FFF);
    rd(2, 4, 7); chk("t2_r4_noinit", data_a, 32'h0); chk("t2_r7", data_b, 32'hDEAD_BEEF);

    // Reset in the middle of a clear
    init_req = 1'b1; init_trd = 3'd6; init_data = 32'h42;
    tick();
    init_req = 1'b0;
    chk("busy_t6", 32'(init_busy), 32'h1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(init_busy), 32'h0);
    chk("rst_mid_data", data_a, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(init_busy), 32'h0);
    rd(6, 10, 4); chk("rst_t6_r10", data_a, 32'h0);        chk("rst_t6_r4", data_b, 32'h0);
    rd(6, 2, 1);  chk("rst_t6_r2", data_a, 32'h0001_09FF); chk("rst_t6_r1", data_b, 32'h6);
    rd(2, 7, 0);  chk("rst_t2_r7", data_a, 32'h0);
    rd(1, 4, 5);  chk("rst_t1_r4", data_a, 32'h0);         chk("rst_t1_r5", data_b, 32'h0);
    rd(0, 20, 3); chk("rst_t0_r20", data_a, 32'h0);        chk("rst_t0_r3", data_b, 32'h0001_0FFF);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mt_regfile.md
# mt_regfile

Multi-thread register file holding the architectural registers of all hardware threads in one block, replacing per-thread instances. It sits between decode (two read ports) and writeback (one write port), and the thread scheduler drives its context-init port. Reads are registered, with optional same-cycle write bypass. Thread initialisation is a multi-cycle clear sequenced by an internal FSM.

## Interface
- NUM_TRD, 8: number of hardware threads (power of two, ≥2)
- NUM_REG, 32: registers per thread (power of two, ≥8)
- DATA_W, 32: register width
- STACK_TOP, 32'h0001_0FFF: initial stack pointer of thread 0
- STACK_STRIDE, 32'h0000_0100: stack spacing; thread t initial ESP = STACK_TOP − t·STACK_STRIDE
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rd_trd  in  log2(NUM_TRD)  thread for both read ports
- rd_a, rd_b  in  log2(NUM_REG)  read register indices
- wr_en  in  1  write strobe
- wr_trd  in  log2(NUM_TRD)  write thread
- wr_reg  in  log2(NUM_REG)  write register index
- wr_data  in  DATA_W  write data
- init_req  in  1  context-init request
- init_trd  in  log2(NUM_TRD)  thread to initialise
- init_data  in  DATA_W  argument value placed in r4
- init_busy  out  1  clear sequence in progress; init_req ignored while high
- data_a, data_b  out  DATA_W  registered read data

## Operation
- Context layout per thread t: r0 = 0 (hard), r1 = t (read-only), r2 = r3 = ESP(t), r4 = argument, r5..r(NUM_REG−1) general.
- Writes with wr_reg ∈ {0,1} are dropped; others update the wr_trd entry at the edge.
- Reset: every thread context loaded with layout above, r4..rN = 0; data_a/data_b = 0; init_busy = 0; FSM IDLE.
- FSM IDLE: init_req & !init_busy accepted; at that edge r0..r3 of init_trd reloaded, r4 = init_data, clr_ptr = 5, go CLEAR. NUM_REG ≥ 8 guarantees at least one CLEAR cycle.
- FSM CLEAR: each cycle writes 0 to r[clr_ptr] of latched thread, clr_ptr++; on clr_ptr == NUM_REG−1 write and return IDLE.
- init_busy = (state == CLEAR).
- Writes to the thread being initialised are dropped, from the accept edge through the last CLEAR edge. Writes to other threads proceed normally.
- Reads: data_x <= value of r[rd_x] of rd_trd, where:
  - r0 reads 0.
  - During CLEAR, init thread with index ≥ clr_ptr reads 0.
  - In the accept cycle, reads return pre-init contents.

## Timing
- Read latency 1 cycle: indices at edge N, data valid after edge N.
- Write visible to a read sampled on the following edge; same-edge behaviour per Configuration.
- init_busy rises one cycle after accept and stays high NUM_REG−5 cycles (27 at default). A new init_req is accepted on the cycle init_busy is low again.
- Priority at one edge: reset > init accept/clear > write.
- Reset asserted mid-CLEAR: FSM to IDLE, all contexts reset, clear abandoned.

## Configuration
- MT_REGFILE_BYPASS_EN defined: a read whose (rd_trd, rd_x) matches an accepted same-cycle write returns wr_data. Bypass never applies to r0/r1 or dropped writes.
- Not defined: same-cycle read returns the old stored value. Writeback must be scheduled one cycle ahead.

## Test plan
- Reset, then read r0..r4 of threads 0 and 3 → 0, 0/3, ESP 0x0001_0FFF/0x0001_0CFF twice, 0.
- Write t2 r7 = 0xDEAD_BEEF and read t2 r7 the same cycle:
  - With bypass: data_a = 0xDEAD_BEEF.
  - Without bypass: data_a = 0, then 0xDEAD_BEEF next read.
- Write to r0 and r1 of t5 = 0xFFFF_FFFF → reads remain 0 and 5.
- Fill t1 r5..r31 with 0xA5A5_A5A5, then init t1 with init_data 0x1234:
  - init_busy high 27 cycles.
  - r4 = 0x1234; r5..r31 = 0, including reads ahead of clr_ptr mid-clear.
  - t0 contents unchanged.
- During CLEAR of t1:
  - Write t1 r10 → dropped.
  - Write t6 r10 = 0x55 → stored.
  - Second init_req → ignored.
- Assert rst_n low mid-CLEAR → init_busy = 0 and all contexts at reset values on release.
